bcm_bunch_integrator: RTL and testbench

- System-clock-domain readout engine downstream of the BCM acquisition block.
- After an acquisition completes, walks the accumulated DPRAM for every channel, sample by sample, using the acquisition block's address-word/readout-register interface.
- Subtracts a programmable baseline, sums each group of SAMPLES_PER_BUNCH samples into one per-bunch charge word, and streams the results out over a valid/ready handshake.

---
 rtl/bcm_pkg.sv | 32 +++
 rtl/bcm_addr_word_pack.sv | 24 ++
 rtl/bcm_bunch_integrator.sv | 233 +++++++++++++++++++++++
 tb/tb_bcm_bunch_integrator.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcm_pkg.sv
// Shared types and helpers for the BCM bunch integrator.
// Address-word layout, FSM states and result record.
package bcm_pkg;

  localparam int SAMPLE_LSB  = 0;
  localparam int CHANNEL_LSB = 24;

  function automatic int siw(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int ciw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    SETTLE,
    CAPTURE,
    EMIT,
    FINISH
  } bcm_state_e;

  typedef struct packed {
    logic [7:0]         channel;
    logic [31:0]        bunch;
    logic signed [63:0] sum;
    logic               last;
  } bcm_out_t;

endpackage

// File: rtl/bcm_addr_word_pack.sv
// Packs {channel, address, sample} into the readout address word.
// Shared layout with the acquisition block's software model.
module bcm_addr_word_pack
  import bcm_pkg::*;
#(
  parameter int DAW = 10,
  parameter int SIW = 4,
  parameter int CIW = 1
) (
  input  logic [CIW-1:0] channel_i,
  input  logic [DAW-1:0] addr_i,
  input  logic [SIW-1:0] sample_i,
  output logic [31:0]    word_o
);

  // Field placement; unused bits stay zero.
  always_comb begin
    word_o = '0;
    word_o[SAMPLE_LSB +: SIW]  = sample_i;
    word_o[SIW +: DAW]         = addr_i;
    word_o[CHANNEL_LSB +: CIW] = channel_i;
  end

endmodule

// File: rtl/bcm_bunch_integrator.sv
// Sweeps the acquisition DPRAM, subtracts a baseline and
// sums groups of samples into per-bunch charge words.
module bcm_bunch_integrator
  import bcm_pkg::*;
#(
  parameter int CHANNEL_COUNT         = 2,
  parameter int AXI_SAMPLES_PER_CLOCK = 8,
  parameter int DPRAM_ADDRESS_WIDTH   = 10,
  parameter int SAMPLES_PER_BUNCH     = 4,
  parameter int SETTLE_CYCLES         = 8,
  parameter int READOUT_SHIFT         = 0,
  parameter int SUM_WIDTH             = 40,
  localparam int SIW = siw(AXI_SAMPLES_PER_CLOCK),
  localparam int CIW = ciw(CHANNEL_COUNT),
  localparam int DAW = DPRAM_ADDRESS_WIDTH,
  localparam int BW  = DAW + SIW
) (
  input  logic                        sysClk,
  input  logic                        sysReset_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [DAW-1:0]              lastAddress,
  input  logic signed [31:0]          baseline,
  output logic [31:0]                 rdAddrWord,
  output logic                        rdAddrStrobe,
  input  logic signed [31:0]          rdData,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [CIW-1:0]              outChannel,
  output logic [BW-1:0]               outBunch,
  output logic signed [SUM_WIDTH-1:0] outSum,
  output logic                        outLast,
  output logic                        busy,
  output logic                        done
);

  localparam int GW  = $clog2(SAMPLES_PER_BUNCH + 1);
  localparam int SCW = $clog2(SETTLE_CYCLES);
  localparam int BSH = $clog2(SAMPLES_PER_BUNCH);

  localparam logic [SIW-1:0] SMAX  = SIW'(AXI_SAMPLES_PER_CLOCK - 1);
  localparam logic [CIW-1:0] CMAX  = CIW'(CHANNEL_COUNT - 1);
  localparam logic [GW-1:0]  GFULL = GW'(SAMPLES_PER_BUNCH);
  localparam logic [SCW-1:0] SLOAD = SCW'(SETTLE_CYCLES - 1);
  localparam logic [SCW-1:0] SONE  = SCW'(1);
  localparam logic [BW-1:0]  AXI_B = BW'(AXI_SAMPLES_PER_CLOCK);

  bcm_state_e state_q, state_d;

  logic [CIW-1:0]              ch_q, ch_d;
  logic [DAW-1:0]              addr_q, addr_d;
  logic [SIW-1:0]              smp_q, smp_d;
  logic [DAW-1:0]              last_q, last_d;
  logic signed [31:0]          base_q, base_d;
  logic [GW-1:0]               grp_q, grp_d;
  logic [SCW-1:0]              settle_q, settle_d;
  logic signed [SUM_WIDTH-1:0] acc_q, acc_d;
  logic                        busy_q, busy_d;
  logic [CIW-1:0]              och_q, och_d;
  logic [BW-1:0]               obunch_q, obunch_d;
  logic signed [SUM_WIDTH-1:0] osum_q, osum_d;
  logic                        olast_q, olast_d;

  logic [CIW-1:0]              adv_ch;
  logic [DAW-1:0]              adv_addr;
  logic [SIW-1:0]              adv_smp;
  logic [GW-1:0]               grp_inc;
  logic [BW-1:0]               lin;
  logic signed [31:0]          shifted;
  logic signed [32:0]          diff;
  logic signed [SUM_WIDTH-1:0] term;
  logic signed [SUM_WIDTH-1:0] acc_sum;

  bcm_addr_word_pack #(
    .DAW(DAW),
    .SIW(SIW),
    .CIW(CIW)
  ) u_pack (
    .channel_i(ch_q),
    .addr_i   (addr_q),
    .sample_i (smp_q),
    .word_o   (rdAddrWord)
  );

  assign rdAddrStrobe = (state_q == STROBE);
  assign outValid     = (state_q == EMIT);
  assign done         = (state_q == FINISH);
  assign busy         = busy_q;
  assign outChannel   = och_q;
  assign outBunch     = obunch_q;
  assign outSum       = osum_q;
  assign outLast      = olast_q;

  // Next sample position: sample, then address, then channel.
  always_comb begin
    adv_smp  = smp_q + 1'b1;
    adv_addr = addr_q;
    adv_ch   = ch_q;
    if (smp_q == SMAX) begin
      adv_smp  = '0;
      adv_addr = addr_q + 1'b1;
      if (addr_q == last_q) begin
        adv_addr = '0;
        adv_ch   = ch_q + 1'b1;
      end
    end
  end

  // Baseline-corrected term, bunch index and running sum.
  always_comb begin
    shifted = rdData >>> READOUT_SHIFT;
    diff    = {shifted[31], shifted} - {base_q[31], base_q};
    term    = {{(SUM_WIDTH-33){diff[32]}}, diff};
    acc_sum = acc_q + term;
    grp_inc = grp_q + 1'b1;
    lin     = BW'(addr_q) * AXI_B + BW'(smp_q);
  end

  // Sweep sequencing and result capture.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    addr_d   = addr_q;
    smp_d    = smp_q;
    last_d   = last_q;
    base_d   = base_q;
    grp_d    = grp_q;
    settle_d = settle_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    och_d    = och_q;
    obunch_d = obunch_q;
    osum_d   = osum_q;
    olast_d  = olast_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          last_d  = lastAddress;
          base_d  = baseline;
          ch_d    = '0;
          addr_d  = '0;
          smp_d   = '0;
          acc_d   = '0;
          grp_d   = '0;
          busy_d  = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE: begin
        settle_d = SLOAD;
        state_d  = SETTLE;
      end
      SETTLE: begin
        settle_d = settle_q - 1'b1;
        if (settle_q == SONE) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (grp_inc == GFULL) begin
          och_d    = ch_q;
          obunch_d = lin >> BSH;
          osum_d   = acc_sum;
          olast_d  = (ch_q == CMAX) && (addr_q == last_q)
                     && (smp_q == SMAX);
          acc_d    = '0;
          grp_d    = '0;
          state_d  = EMIT;
        end else begin
          acc_d   = acc_sum;
          grp_d   = grp_inc;
          ch_d    = adv_ch;
          addr_d  = adv_addr;
          smp_d   = adv_smp;
          state_d = STROBE;
        end
      end
      EMIT: begin
        if (outReady) begin
          ch_d    = adv_ch;
          addr_d  = adv_addr;
          smp_d   = adv_smp;
          state_d = olast_q ? FINISH : STROBE;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      acc_d   = '0;
      grp_d   = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      addr_q   <= '0;
      smp_q    <= '0;
      last_q   <= '0;
      base_q   <= '0;
      grp_q    <= '0;
      settle_q <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      och_q    <= '0;
      obunch_q <= '0;
      osum_q   <= '0;
      olast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      addr_q   <= addr_d;
      smp_q    <= smp_d;
      last_q   <= last_d;
      base_q   <= base_d;
      grp_q    <= grp_d;
      settle_q <= settle_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      och_q    <= och_d;
      obunch_q <= obunch_d;
      osum_q   <= osum_d;
      olast_q  <= olast_d;
    end
  end

endmodule

// File: tb/tb_bcm_bunch_integrator.sv
// Directed bench for bcm_bunch_integrator.
// Readout model answers each strobe SETTLE cycles later.
module tb_bcm_bunch_integrator;
  import bcm_pkg::*;

  localparam int SETTLE = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [9:0]         lastAddress = '0;
  logic signed [31:0] baseline = '0;
  logic signed [31:0] rdData = '0;
  logic               outReady = 1'b1;

  logic [31:0]        rdAddrWord, rdAddrWord1;
  logic               rdAddrStrobe, rdAddrStrobe1;
  logic               outValid, outValid1;
  logic [0:0]         outChannel, outChannel1;
  logic [13:0]        outBunch, outBunch1;
  logic signed [39:0] outSum, outSum1;
  logic               outLast, outLast1;
  logic               busy, busy1;
  logic               done, done1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mode = 0;
  int nstrb = 0;
  int ndone = 0;
  int hs_cyc = 0;
  int done_cyc = 0;
  bit got_first = 0;
  logic [31:0] first_word = '0;
  logic [31:0] sched [int];
  bcm_out_t rq[$];
  logic signed [63:0] r1q[$];

  bcm_bunch_integrator dut (
    .sysClk(clk), .sysReset_n(rst_n), .start(start), .abort(abort),
    .lastAddress(lastAddress), .baseline(baseline),
    .rdAddrWord(rdAddrWord), .rdAddrStrobe(rdAddrStrobe),
    .rdData(rdData), .outValid(outValid), .outReady(outReady),
    .outChannel(outChannel), .outBunch(outBunch), .outSum(outSum),
    .outLast(outLast), .busy(busy), .done(done)
  );

  bcm_bunch_integrator #(.READOUT_SHIFT(4)) dut_sh (
    .sysClk(clk), .sysReset_n(rst_n), .start(start), .abort(abort),
    .lastAddress(lastAddress), .baseline(baseline),
    .rdAddrWord(rdAddrWord1), .rdAddrStrobe(rdAddrStrobe1),
    .rdData(rdData), .outValid(outValid1), .outReady(outReady),
    .outChannel(outChannel1), .outBunch(outBunch1), .outSum(outSum1),
    .outLast(outLast1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [31:0] w);
    case (mode)
      0: model = {28'd0, w[3:0]};
      1: model = 32'd100;
      default: model = 32'hFFFF_FF00;
    endcase
  endfunction

  // Readout register: valid only in the capture cycle.
  always @(negedge clk) begin
    if (rdAddrStrobe) sched[cyc + SETTLE] = model(rdAddrWord);
    if (sched.exists(cyc)) begin
      rdData = sched[cyc];
      sched.delete(cyc);
    end else begin
      rdData = 32'h5A5A_5A5A;
    end
  end

  // Output and event monitor.
  always @(negedge clk) begin
    bcm_out_t r;
    if (rdAddrStrobe) begin
      nstrb++;
      if (!got_first) begin
        first_word = rdAddrWord;
        got_first = 1;
      end
    end
    if (outValid && outReady) begin
      r.channel = 8'(outChannel);
      r.bunch = 32'(outBunch);
      r.sum = {{24{outSum[39]}}, outSum};
      r.last = outLast;
      rq.push_back(r);
      r1q.push_back({{24{outSum1[39]}}, outSum1});
      hs_cyc = cyc;
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kick(input int m, input logic [31:0] b,
                      input logic [9:0] la);
    mode = m;
    baseline = b;
    lastAddress = la;
    rq.delete();
    r1q.delete();
    got_first = 0;
    nstrb = 0;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0 = ndone;
    int n = 0;
    while (ndone == d0 && n < 20000) begin
      tick(1);
      n++;
    end
    chk({tag, "_done"}, 64'(ndone - d0), 64'd1);
    chk({tag, "_dlat"}, 64'(done_cyc), 64'(hs_cyc + 1));
    tick(2);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!outValid && n < 2000) begin
      tick(1);
      n++;
    end
    chk({tag, "_vld"}, 64'(outValid), 64'd1);
  endtask

  task automatic res(input string tag, input int i, input int ch,
                     input int bn, input longint s, input bit l);
    if (i < rq.size()) begin
      chk({tag, "_id"}, {rq[i].channel, rq[i].bunch, 7'd0, rq[i].last},
          {8'(ch), 32'(bn), 7'd0, l});
      chk({tag, "_sum"}, rq[i].sum, 64'(s));
    end else begin
      chk({tag, "_miss"}, 64'(rq.size()), 64'(i + 1));
    end
  endtask

  initial begin
    logic [31:0] snap;
    logic [13:0] snapb;
    logic signed [39:0] snaps;
    int chg;
    int s0;
    int d0;
    bit hit;
    int n;

    tick(3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_vld", 64'(outValid), 64'd0);
    chk("rst_word", 64'(rdAddrWord), 64'd0);
    chk("rst_strb", 64'(rdAddrStrobe), 64'd0);
    chk("rst_out", {outSum, outBunch, outChannel, outLast, done},
        64'd0);
    rst_n = 1'b1;
    tick(2);

    // Sample-index readout, one word per channel.
    kick(0, 0, 0);
    wait_done("t1");
    chk("t1_cnt", 64'(rq.size()), 64'd4);
    chk("t1_strb", 64'(nstrb), 64'd16);
    for (int c = 0; c < 2; c++)
      for (int b = 0; b < 2; b++)
        res($sformatf("t1_%0d%0d", c, b), c * 2 + b, c, b,
            b ? 22 : 6, (c == 1) && (b == 1));

    // Baseline subtract: (100-30)*4.
    kick(1, 30, 0);
    wait_done("t2");
    chk("t2_cnt", 64'(rq.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < rq.size()) chk($sformatf("t2_s%0d", i), rq[i].sum, 64'd280);

    // Negative readout, unshifted and shifted by 4.
    kick(2, 0, 0);
    wait_done("t3");
    chk("t3_cnt", 64'(r1q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < rq.size()) begin
        chk($sformatf("t3_s%0d", i), rq[i].sum, -64'sd1024);
        chk($sformatf("t3_sh%0d", i), r1q[i], -64'sd64);
      end

    // Backpressure on the first result, start ignored while busy.
    outReady = 1'b0;
    kick(0, 0, 1);
    wait_valid("t4");
    snap = rdAddrWord;
    snapb = outBunch;
    snaps = outSum;
    s0 = nstrb;
    chg = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!outValid || outBunch != snapb || outSum != snaps
          || rdAddrWord != snap || outChannel != 1'b0) chg++;
      tick(1);
    end
    chk("t4_hold", 64'(chg), 64'd0);
    chk("t4_nostrb", 64'(nstrb - s0), 64'd0);
    outReady = 1'b1;
    wait_done("t4");
    chk("t4_cnt", 64'(rq.size()), 64'd8);
    for (int c = 0; c < 2; c++)
      for (int b = 0; b < 4; b++)
        res($sformatf("t4_%0d%0d", c, b), c * 4 + b, c, b,
            b[0] ? 22 : 6, (c == 1) && (b == 3));

    // Abort in SETTLE on channel 1 address 3, mid-group.
    kick(0, 0, 3);
    hit = 0;
    n = 0;
    while (!hit && n < 5000) begin
      @(negedge clk);
      if (rdAddrStrobe && rdAddrWord[24] && rdAddrWord[13:4] == 10'd3
          && rdAddrWord[3:0] == 4'd2) hit = 1;
      n++;
    end
    chk("t5_hit", 64'(hit), 64'd1);
    tick(1);
    abort = 1'b1;
    d0 = ndone;
    tick(1);
    abort = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_vld", 64'(outValid), 64'd0);
    s0 = nstrb;
    tick(20);
    chk("t5_nodone", 64'(ndone - d0), 64'd0);
    chk("t5_idle", 64'(nstrb - s0), 64'd0);
    kick(0, 0, 0);
    wait_done("t5b");
    chk("t5_first", 64'(first_word), 64'd0);
    res("t5b_0", 0, 0, 0, 6, 0);
    chk("t5b_cnt", 64'(rq.size()), 64'd4);

    // Start and abort together while idle: abort wins.
    start = 1'b1;
    abort = 1'b1;
    s0 = nstrb;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    tick(12);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_strb", 64'(nstrb - s0), 64'd0);

    // Reset while a result is held.
    outReady = 1'b0;
    kick(0, 0, 0);
    wait_valid("t7");
    rst_n = 1'b0;
    tick(1);
    chk("t7_vld", 64'(outValid), 64'd0);
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_out", {outSum, outBunch, outChannel, outLast, done},
        64'd0);
    chk("t7_word", 64'(rdAddrWord), 64'd0);
    rst_n = 1'b1;
    outReady = 1'b1;
    tick(3);
    chk("t7_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
